branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter CMP_TIMEOUT, default 15, max cycles spent in WAIT for cmp_done before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  control-transfer request present.
REQ-005 req_ready  output  1  sequencer accepts a request this cycle.
REQ-006 op  input  2  0=BRANCH, 1=JAL, 2=JALR, 3=reserved.
REQ-007 funct3  input  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-008 pc, rs1, rs2, imm  input  32 each  instruction PC, operands, sign-extended immediate.
REQ-009 cmp_start  output  1  one-cycle start pulse to the external compare unit.
REQ-010 cmp_rs1, cmp_rs2  output  32 each; cmp_funct3  output  3; registered operands held stable from cmp_start until cmp_done.
REQ-011 cmp_done, cmp_jump  input  1 each  compare result; cmp_jump valid only when cmp_done=1.
REQ-012 resp_valid  output  1  result available; resp_ready  input  1  consumer accepts.
REQ-013 next_pc, link  output  32 each  redirect target / pc+4.
REQ-014 taken, misaligned, illegal, timeout  output  1 each  result flags.

Function
REQ-015 States IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 IDLE: on req_valid capture pc, rs1, rs2, imm, op, funct3; BRANCH with legal funct3 -> ISSUE; JAL/JALR -> RESP; illegal funct3 (010, 011) or op=3 -> RESP with illegal=1, taken=0, next_pc=pc+4.
REQ-017 ISSUE: cmp_start=1 exactly one cycle, clear timeout counter -> WAIT.
REQ-018 WAIT: cmp_done=1 -> latch cmp_jump into taken -> RESP; otherwise increment 4-bit counter; counter reaching CMP_TIMEOUT without cmp_done -> RESP with timeout=1, taken=0, next_pc=pc+4.
REQ-019 cmp_done arriving the same cycle the counter reaches CMP_TIMEOUT: done wins, timeout=0.
REQ-020 BRANCH target = pc+imm (32-bit, wrap-around, carry discarded); next_pc = target if taken else pc+4.
REQ-021 JAL: taken=1, next_pc=pc+imm; JALR: taken=1, next_pc=(rs1+imm) with bit0 cleared; no compare issued for either.
REQ-022 link = pc+4 (wraps 0xFFFFFFFC -> 0x00000000) for every op.
REQ-023 misaligned=1 when taken=1 and next_pc[1:0]!=0; next_pc still reports the computed target.
REQ-024 RESP: resp_valid=1 with all result outputs stable until resp_ready=1; transfer cycle -> IDLE; new request accepted earliest the following cycle.
REQ-025 Latency: JAL/JALR resp_valid 1 cycle after acceptance; BRANCH resp_valid 1 cycle after cmp_done sampled.
REQ-026 cmp_done/cmp_jump ignored outside WAIT.

Reset
REQ-027 rst=1 forces IDLE from any state, including mid-WAIT or RESP; stale cmp_done after reset is ignored.
REQ-028 Reset values: req_ready=1 (first cycle after rst deasserts), cmp_start=0, resp_valid=0, taken=0, misaligned=0, illegal=0, timeout=0, next_pc=0, link=0, cmp_rs1=0, cmp_rs2=0, cmp_funct3=0, counter=0.

Structure
REQ-029 Shared package holds op encoding enum, funct3 condition constants (shared with the compare unit), and the state typedef.
REQ-030 Compare unit remains external; one natural sub-module, branch_target_calc, computes pc+imm, rs1+imm (bit0 cleared), pc+4 combinationally.

Verification
REQ-031 BRANCH BEQ pc=0x100, rs1=rs2=5, imm=0x20, compare returns jump=1 after 2 cycles -> one cmp_start pulse, next_pc=0x120, taken=1, link=0x104.
REQ-032 BLTU rs1=0xFFFFFFFF, rs2=1, compare jump=0, resp_ready low 3 cycles -> next_pc=pc+4, outputs stable while stalled, req_ready=0 until transfer.
REQ-033 JALR rs1=0x1001, imm=2 -> no cmp_start, next_pc=0x1002, taken=1, misaligned=1, resp_valid 1 cycle after accept.
REQ-034 BRANCH with cmp_done never asserted, CMP_TIMEOUT=15 -> timeout=1, taken=0, next_pc=pc+4; then cmp_done pulse in IDLE ignored.
REQ-035 funct3=010 -> no cmp_start, illegal=1, next_pc=pc+4; JAL pc=0xFFFFFFFC, imm=8 -> next_pc=0x4, link=0x0.
REQ-036 rst asserted in WAIT, cmp_done pulsed next cycle -> IDLE, resp_valid stays 0, next request proceeds normally.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer and the external compare unit.
//   op_e          : control-transfer opcode encoding on the request port
//   F3_*          : branch condition codes (funct3), also decoded by the compare unit
//   state_t/ST_*  : sequencer FSM state encoding, exposed on the debug port
//   funct3_legal  : true for the six defined branch conditions
package branch_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // 010 and 011 are the only undefined branch conditions.
    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Bundle of the sequencer's request, compare-unit and response signals.
//   request  : req_valid/req_ready, op, funct3, pc, rs1, rs2, imm
//   compare  : cmp_start, cmp_rs1, cmp_rs2, cmp_funct3 out; cmp_done, cmp_jump in
//   response : resp_valid/resp_ready, next_pc, link, taken, misaligned, illegal, timeout
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge;
// ready never depends combinationally on valid. cmp_start/cmp_done are not a
// valid/ready pair: cmp_start is a single-cycle pulse and cmp_done is a pulse
// that is only meaningful while the sequencer is waiting for it.
interface branch_sequencer_if;
    import branch_sequencer_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;

    logic        cmp_start;
    logic [31:0] cmp_rs1;
    logic [31:0] cmp_rs2;
    logic [2:0]  cmp_funct3;
    logic        cmp_done;
    logic        cmp_jump;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        taken;
    logic        misaligned;
    logic        illegal;
    logic        timeout;

    // Sequencer side.
    modport slave (
        input  req_valid, op, funct3, pc, rs1, rs2, imm,
        input  cmp_done, cmp_jump, resp_ready,
        output req_ready, cmp_start, cmp_rs1, cmp_rs2, cmp_funct3,
        output resp_valid, next_pc, link, taken, misaligned, illegal, timeout
    );

    // Environment side: request source, compare unit and response consumer.
    modport master (
        output req_valid, op, funct3, pc, rs1, rs2, imm,
        output cmp_done, cmp_jump, resp_ready,
        input  req_ready, cmp_start, cmp_rs1, cmp_rs2, cmp_funct3,
        input  resp_valid, next_pc, link, taken, misaligned, illegal, timeout
    );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational address arithmetic for control transfers.
//   pc_i, rs1_i, imm_i : instruction PC, base register, sign-extended immediate
//   pc_imm_o           : pc + imm (branch / JAL target), 32-bit wrap
//   rs1_imm_o          : (rs1 + imm) with bit 0 cleared (JALR target)
//   pc4_o              : pc + 4 (fall-through and link address), 32-bit wrap
module branch_target_calc (
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] imm_i,
    output logic [31:0] pc_imm_o,
    output logic [31:0] rs1_imm_o,
    output logic [31:0] pc4_o
);

    assign pc_imm_o  = pc_i + imm_i;
    assign rs1_imm_o = (rs1_i + imm_i) & ~32'd1;
    assign pc4_o     = pc_i + 32'd4;

endmodule

// File: rtl/branch_sequencer.sv
// Control-transfer sequencer: accepts BRANCH/JAL/JALR requests, runs branch
// conditions through an external compare unit and returns the redirect target.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : request, compare-unit and response signals (branch_sequencer_if)
//   dbg_state_o  : current FSM state (ST_* encoding from the package)
// Parameter CMP_TIMEOUT: maximum number of cycles spent waiting for cmp_done.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int CMP_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    branch_sequencer_if.slave   bus,
    output state_t              dbg_state_o
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] cmp_rs1_q, cmp_rs1_d;
    logic [31:0] cmp_rs2_q, cmp_rs2_d;
    logic [2:0]  cmp_f3_q, cmp_f3_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] link_q, link_d;
    logic        taken_q, taken_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;
    logic        tmo_q, tmo_d;

    // Result of the transition into RESP, committed to the output registers
    // only on that transition so the outputs stay frozen while stalled.
    logic [31:0] r_next;
    logic        r_taken;
    logic        r_ill;
    logic        r_tmo;
    logic [3:0]  cnt_inc;

    logic        in_idle;
    logic [31:0] calc_pc, calc_imm;
    logic [31:0] pc_imm, rs1_imm, pc4;

    // JAL/JALR resolve in the acceptance cycle, so the adder sees the live
    // request in IDLE and the captured branch operands everywhere else.
    assign in_idle  = (state_q == ST_IDLE);
    assign calc_pc  = in_idle ? bus.pc  : pc_q;
    assign calc_imm = in_idle ? bus.imm : imm_q;

    branch_target_calc u_calc (
        .pc_i      (calc_pc),
        .rs1_i     (bus.rs1),
        .imm_i     (calc_imm),
        .pc_imm_o  (pc_imm),
        .rs1_imm_o (rs1_imm),
        .pc4_o     (pc4)
    );

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        cmp_rs1_d = cmp_rs1_q;
        cmp_rs2_d = cmp_rs2_q;
        cmp_f3_d  = cmp_f3_q;
        next_pc_d = next_pc_q;
        link_d    = link_q;
        taken_d   = taken_q;
        mis_d     = mis_q;
        ill_d     = ill_q;
        tmo_d     = tmo_q;
        r_next    = pc4;
        r_taken   = 1'b0;
        r_ill     = 1'b0;
        r_tmo     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    pc_d      = bus.pc;
                    imm_d     = bus.imm;
                    cmp_rs1_d = bus.rs1;
                    cmp_rs2_d = bus.rs2;
                    cmp_f3_d  = bus.funct3;
                    state_d   = ST_RESP;
                    case (op_e'(bus.op))
                        OP_BRANCH: begin
                            if (funct3_legal(bus.funct3)) state_d = ST_ISSUE;
                            else                          r_ill   = 1'b1;
                        end
                        OP_JAL: begin
                            r_taken = 1'b1;
                            r_next  = pc_imm;
                        end
                        OP_JALR: begin
                            r_taken = 1'b1;
                            r_next  = rs1_imm;
                        end
                        default: r_ill = 1'b1;
                    endcase
                end
            end
            ST_ISSUE: begin
                cnt_d   = 4'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the final allowed cycle is still honoured.
                if (bus.cmp_done) begin
                    r_taken = bus.cmp_jump;
                    r_next  = bus.cmp_jump ? pc_imm : pc4;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 4'(CMP_TIMEOUT)) begin
                        r_tmo   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            default: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_RESP && state_d == ST_RESP) begin
            next_pc_d = r_next;
            link_d    = pc4;
            taken_d   = r_taken;
            mis_d     = r_taken && (r_next[1:0] != 2'b00);
            ill_d     = r_ill;
            tmo_d     = r_tmo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pc_q      <= 32'd0;
            imm_q     <= 32'd0;
            cmp_rs1_q <= 32'd0;
            cmp_rs2_q <= 32'd0;
            cmp_f3_q  <= 3'd0;
            next_pc_q <= 32'd0;
            link_q    <= 32'd0;
            taken_q   <= 1'b0;
            mis_q     <= 1'b0;
            ill_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            cmp_rs1_q <= cmp_rs1_d;
            cmp_rs2_q <= cmp_rs2_d;
            cmp_f3_q  <= cmp_f3_d;
            next_pc_q <= next_pc_d;
            link_q    <= link_d;
            taken_q   <= taken_d;
            mis_q     <= mis_d;
            ill_q     <= ill_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.cmp_start  = (state_q == ST_ISSUE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.cmp_rs1    = cmp_rs1_q;
    assign bus.cmp_rs2    = cmp_rs2_q;
    assign bus.cmp_funct3 = cmp_f3_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.link       = link_q;
    assign bus.taken      = taken_q;
    assign bus.misaligned = mis_q;
    assign bus.illegal    = ill_q;
    assign bus.timeout    = tmo_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;
    import branch_sequencer_pkg::*;

    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    always #5 clk = ~clk;

    branch_sequencer_if bus();

    branch_sequencer #(.CMP_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] next_pc;
        logic [31:0] link;
        logic        taken;
        logic        mis;
        logic        ill;
        logic        tmo;
        logic        uses_cmp;
        int          resp_cycle;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic cond_true(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // delay: cycles in WAIT before the compare unit answers; 0 = never answers.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [31:0] pc, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input int delay);
        exp_t e;
        e.link = pc + 32'd4;
        e.next_pc = pc + 32'd4;
        e.taken = 1'b0;
        e.ill = 1'b0;
        e.tmo = 1'b0;
        e.uses_cmp = 1'b0;
        if (op == 2'd1) begin
            e.taken = 1'b1;
            e.next_pc = pc + imm;
        end else if (op == 2'd2) begin
            e.taken = 1'b1;
            e.next_pc = (rs1 + imm) & 32'hFFFF_FFFE;
        end else if (op == 2'd0 && f3 != 3'b010 && f3 != 3'b011) begin
            e.uses_cmp = 1'b1;
            if (delay == 0 || delay > TMO) begin
                e.tmo = 1'b1;
            end else begin
                e.taken = cond_true(f3, rs1, rs2);
                e.next_pc = e.taken ? pc + imm : pc + 32'd4;
            end
        end else begin
            e.ill = 1'b1;
        end
        e.mis = e.taken && (e.next_pc[1:0] != 2'b00);
        // Acceptance edge is cycle 0; a compare costs one ISSUE cycle, the
        // waiting cycles, and one cycle to present the result.
        if (!e.uses_cmp) e.resp_cycle = 1;
        else if (e.tmo)  e.resp_cycle = TMO + 2;
        else             e.resp_cycle = delay + 2;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input exp_t e, input logic [31:0] exp_next);
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, ".req_ready"},  32'(bus.req_ready),  32'd0);
        chk({tag, ".next_pc"},    bus.next_pc,         exp_next);
        chk({tag, ".link"},       bus.link,            e.link);
        chk({tag, ".taken"},      32'(bus.taken),      32'(e.taken));
        chk({tag, ".misaligned"}, 32'(bus.misaligned), 32'(e.mis));
        chk({tag, ".illegal"},    32'(bus.illegal),    32'(e.ill));
        chk({tag, ".timeout"},    32'(bus.timeout),    32'(e.tmo));
    endtask

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (bus.req_ready !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm);
        bus.req_valid = 1'b1;
        bus.op = op;
        bus.funct3 = f3;
        bus.pc = pc;
        bus.rs1 = rs1;
        bus.rs2 = rs2;
        bus.imm = imm;
        tick();
        // Scramble the request lines so any late sampling shows up.
        bus.req_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.funct3 = 3'($urandom);
        bus.pc = $urandom;
        bus.rs1 = $urandom;
        bus.rs2 = $urandom;
        bus.imm = $urandom;
    endtask

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm,
                           input int delay, input int stall);
        exp_t e;
        logic [31:0] exp_next;
        int starts, s, r, c;
        e = model(op, f3, pc, rs1, rs2, imm, delay);
        exp_q.push_back(e.next_pc);
        wait_ready(tag);
        drive_req(op, f3, pc, rs1, rs2, imm);
        starts = 0;
        s = -1;
        r = -1;
        c = 1;
        while (r < 0 && c <= 40) begin
            if (bus.cmp_start === 1'b1) begin
                starts++;
                s = c;
                chk({tag, ".cmp_rs1"},    bus.cmp_rs1,         rs1);
                chk({tag, ".cmp_rs2"},    bus.cmp_rs2,         rs2);
                chk({tag, ".cmp_funct3"}, 32'(bus.cmp_funct3), 32'(f3));
            end
            if (bus.resp_valid === 1'b1) begin
                r = c;
            end else begin
                if (s > 0 && c > s && (c - s) == delay) begin
                    bus.cmp_done = 1'b1;
                    bus.cmp_jump = cond_true(f3, rs1, rs2);
                    chk({tag, ".cmp_rs1_held"}, bus.cmp_rs1, rs1);
                end else begin
                    bus.cmp_done = 1'b0;
                    bus.cmp_jump = 1'($urandom);
                end
                tick();
                c++;
            end
        end
        bus.cmp_done = 1'b0;
        exp_next = exp_q.pop_front();
        if (r < 0) begin
            chk({tag, ".resp_arrived"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, ".latency"},    32'(r),      32'(e.resp_cycle));
        chk({tag, ".cmp_starts"}, 32'(starts), 32'(e.uses_cmp));
        check_outputs(tag, e, exp_next);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_outputs({tag, ".stall"}, e, exp_next);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk({tag, ".resp_done"},  32'(bus.resp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(bus.req_ready),  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.op = 2'd0;
        bus.funct3 = 3'd0;
        bus.pc = 32'd0;
        bus.rs1 = 32'd0;
        bus.rs2 = 32'd0;
        bus.imm = 32'd0;
        bus.cmp_done = 1'b0;
        bus.cmp_jump = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst.req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst.cmp_start",  32'(bus.cmp_start),  32'd0);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.flags", {28'd0, bus.taken, bus.misaligned, bus.illegal, bus.timeout}, 32'd0);
        chk("rst.next_pc",    bus.next_pc,         32'd0);
        chk("rst.link",       bus.link,            32'd0);
        chk("rst.cmp_rs1",    bus.cmp_rs1,         32'd0);
        chk("rst.cmp_rs2",    bus.cmp_rs2,         32'd0);
        chk("rst.cmp_funct3", 32'(bus.cmp_funct3), 32'd0);

        // Directed cases.
        run_txn("beq",   2'd0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 2, 0);
        run_txn("bltu",  2'd0, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3, 3);
        run_txn("jalr",  2'd2, 3'b000, 32'h300, 32'h1001, 32'd0, 32'd2, 0, 0);
        run_txn("tmo",   2'd0, 3'b000, 32'h400, 32'd1, 32'd1, 32'h10, 0, 0);

        // Stray compare result while idle must be ignored.
        bus.cmp_done = 1'b1;
        bus.cmp_jump = 1'b1;
        tick();
        bus.cmp_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("idle_done.req_ready",  32'(bus.req_ready),  32'd1);
            chk("idle_done.resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("idle_done.cmp_start",  32'(bus.cmp_start),  32'd0);
            tick();
        end

        run_txn("ill",    2'd0, 3'b010, 32'h500, 32'd7, 32'd7, 32'h8, 1, 1);
        run_txn("jal_wr", 2'd1, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 0, 0);
        run_txn("late",   2'd0, 3'b001, 32'h600, 32'd3, 32'd4, 32'h6, TMO, 1);
        run_txn("blt",    2'd0, 3'b100, 32'h700, 32'hFFFF_FFF0, 32'd2, 32'hFFFF_FF00, 1, 0);
        run_txn("rsvd",   2'd3, 3'b000, 32'h800, 32'd0, 32'd0, 32'h4, 0, 2);

        // Reset while waiting for the compare unit, then a late cmp_done.
        wait_ready("rst_wait");
        drive_req(2'd0, 3'b000, 32'h900, 32'd9, 32'd9, 32'h40);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cmp_done = 1'b1;
        bus.cmp_jump = 1'b1;
        tick();
        bus.cmp_done = 1'b0;
        chk("rst_wait.next_pc", bus.next_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait.resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst_wait.req_ready",  32'(bus.req_ready),  32'd1);
            chk("rst_wait.cmp_start",  32'(bus.cmp_start),  32'd0);
            tick();
        end
        run_txn("after_rst", 2'd0, 3'b101, 32'hA00, 32'd4, 32'd4, 32'h14, 4, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [2:0]  f3;
            logic [31:0] pc, rs1, rs2, imm;
            op  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            pc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rs2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            run_txn("rand", op, f3, pc, rs1, rs2, imm,
                    $urandom_range(0, TMO), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
